// File: rtl/int_mul_param_iter.sv
// Iterative shift-add multiplier producing the full 2*p_nbits product with a signed/unsigned mode per request.
// Optional macro INT_MUL_EARLY_EXIT_EN: leave CALC once the remaining multiplier bits are all zero.
module int_mul_param_iter #(
    parameter int p_nbits     = 32,
    parameter int p_cnt_nbits = $clog2(p_nbits)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   istream_val,
    output logic                   istream_rdy,
    input  logic [2*p_nbits-1:0]   istream_msg,
    input  logic                   istream_signed,
    output logic                   ostream_val,
    input  logic                   ostream_rdy,
    output logic [2*p_nbits-1:0]   ostream_msg
);
    localparam int W2 = 2 * p_nbits;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state, state_nxt;
    logic [p_cnt_nbits-1:0] cnt;
    logic [W2-1:0]          a_reg;
    logic [W2-1:0]          acc;
    logic [p_nbits-1:0]     b_reg;
    logic                   neg;
    logic [p_nbits-1:0]     a_in, b_in;
    logic                   in_fire, out_fire, calc_last;

    // Magnitude of an N-bit operand; -2^(N-1) maps to 2^(N-1), which still fits unsigned.
    function automatic logic [p_nbits-1:0] magnitude(input logic [p_nbits-1:0] x, input logic sgn);
        return (sgn && x[p_nbits-1]) ? ((~x) + p_nbits'(1)) : x;
    endfunction

    function automatic logic [W2-1:0] apply_sign(input logic [W2-1:0] x, input logic n);
        return n ? ((~x) + W2'(1)) : x;
    endfunction

    assign a_in     = istream_msg[W2-1:p_nbits];
    assign b_in     = istream_msg[p_nbits-1:0];
    assign in_fire  = istream_val && istream_rdy;
    assign out_fire = ostream_val && ostream_rdy;

`ifdef INT_MUL_EARLY_EXIT_EN
    assign calc_last = (cnt == p_cnt_nbits'(p_nbits - 1)) || (b_reg[p_nbits-1:1] == '0);
`else
    assign calc_last = (cnt == p_cnt_nbits'(p_nbits - 1));
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        istream_rdy = 1'b0;
        ostream_val = 1'b0;
        case (state)
            IDLE: begin
                istream_rdy = reset;
                if (istream_val && reset) state_nxt = CALC;
            end
            CALC: begin
                if (calc_last) state_nxt = DONE;
            end
            DONE: begin
                ostream_val = reset;
                if (ostream_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            acc   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            neg   <= 1'b0;
        end else if (in_fire) begin
            a_reg <= {{p_nbits{1'b0}}, magnitude(a_in, istream_signed)};
            b_reg <= magnitude(b_in, istream_signed);
            neg   <= istream_signed && (a_in[p_nbits-1] ^ b_in[p_nbits-1]);
            acc   <= '0;
            cnt   <= '0;
        end else if (state == CALC) begin
            if (b_reg[0]) acc <= acc + a_reg;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + p_cnt_nbits'(1);
        end
    end

    // The sign is applied once at the output so DONE holds a stable value under back-pressure.
    assign ostream_msg = apply_sign(acc, neg);

`ifndef SYNTHESIS
    task display_trace();
        $display("imul %s cnt=%0d a=%h b=%h acc=%h neg=%b msg=%h",
                 state.name(), cnt, a_reg, b_reg, acc, neg, ostream_msg);
    endtask
`endif

endmodule

// File: tb/tb_int_mul_param_iter.sv
// Directed bench for int_mul_param_iter: 32-bit and 8-bit instances, latency, back-pressure and reset cases.
module tb_int_mul_param_iter;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_val, in_rdy, in_sgn, out_val, out_rdy;
    logic [63:0] in_msg, out_msg;
    logic        in_val8, in_rdy8, in_sgn8, out_val8, out_rdy8;
    logic [15:0] in_msg8, out_msg8;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    int_mul_param_iter #(.p_nbits(32)) dut (
        .clk(clk), .reset(reset),
        .istream_val(in_val), .istream_rdy(in_rdy), .istream_msg(in_msg), .istream_signed(in_sgn),
        .ostream_val(out_val), .ostream_rdy(out_rdy), .ostream_msg(out_msg)
    );

    int_mul_param_iter #(.p_nbits(8)) dut8 (
        .clk(clk), .reset(reset),
        .istream_val(in_val8), .istream_rdy(in_rdy8), .istream_msg(in_msg8), .istream_signed(in_sgn8),
        .ostream_val(out_val8), .ostream_rdy(out_rdy8), .ostream_msg(out_msg8)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Number of CALC cycles expected for a latched multiplier magnitude.
    function automatic int calc_len(input logic [63:0] bmag, input int n);
        int l;
        int early;
        l = 1;
        for (int i = 0; i < n; i++) if (bmag[i]) l = i + 1;
`ifdef INT_MUL_EARLY_EXIT_EN
        early = 1;
`else
        early = 0;
`endif
        return (early != 0) ? l : n;
    endfunction

    task automatic do32(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic [63:0] exp, input int hold);
        int          lat;
        int          w;
        logic [31:0] bmag;
        bmag = (sgn && b[31]) ? (32'd0 - b) : b;
        w = 0;
        while (!in_rdy && w < 100) begin @(posedge clk); #1; w++; end
        check({tag, "_rdy"}, in_rdy, 1'b1);
        in_val = 1'b1; in_msg = {a, b}; in_sgn = sgn;
        @(posedge clk); #1;
        in_val = 1'b0; in_msg = {$urandom, $urandom}; in_sgn = $urandom_range(0, 1);
        lat = 1;
        while (!out_val && lat < 200) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, calc_len({32'd0, bmag}, 32) + 1);
        check({tag, "_msg"}, out_msg, exp);
        if (hold > 0) begin
            out_rdy = 1'b0;
            repeat (hold) @(posedge clk);
            #1;
            check({tag, "_hold"}, {out_val, out_msg}, {1'b1, exp});
            out_rdy = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_done"}, {out_val, in_rdy}, 2'b01);
    endtask

    task automatic do8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic sgn, input logic [15:0] exp);
        int         lat;
        logic [7:0] bmag;
        bmag = (sgn && b[7]) ? (8'd0 - b) : b;
        check({tag, "_rdy"}, in_rdy8, 1'b1);
        in_val8 = 1'b1; in_msg8 = {a, b}; in_sgn8 = sgn;
        @(posedge clk); #1;
        in_val8 = 1'b0; in_msg8 = 16'hA5A5;
        lat = 1;
        while (!out_val8 && lat < 50) begin @(posedge clk); #1; lat++; end
        check({tag, "_lat"}, lat, calc_len({56'd0, bmag}, 8) + 1);
        check({tag, "_msg"}, out_msg8, exp);
        @(posedge clk); #1;
        check({tag, "_done"}, {out_val8, in_rdy8}, 2'b01);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]        ra, rb;
        logic               rs;
        logic signed [63:0] sa, sb;
        logic [63:0]        rexp;
        int                 w;
        int                 saw_val;

        reset = 1'b0;
        in_val = 1'b0; in_msg = '0; in_sgn = 1'b0; out_rdy = 1'b1;
        in_val8 = 1'b0; in_msg8 = '0; in_sgn8 = 1'b0; out_rdy8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {in_rdy, out_val, in_rdy8, out_val8}, 4'b0000);
        check("reset_msg", out_msg, 64'd0);
        reset = 1'b1;
        #1;
        check("post_reset_rdy", {in_rdy, in_rdy8}, 2'b11);

        do32("u_3x2", 32'd3, 32'd2, 1'b0, 64'd6, 0);
        do32("s_m1x7", 32'hFFFF_FFFF, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 0);
        do32("s_minxmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0);
        do32("u_maxxmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0);
        do32("u_bzero", 32'd12345, 32'd0, 1'b0, 64'd0, 0);
        do32("u_7x8", 32'd7, 32'd8, 1'b0, 64'd56, 0);
        do32("s_5xm1", 32'd5, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 0);
        do32("u_big_s0", 32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE, 2);

        do8("s8_m128x127", 8'h80, 8'h7F, 1'b1, 16'hC080);
        do8("u8_200x200", 8'd200, 8'd200, 1'b0, 16'h9C40);
        do8("s8_minxmin", 8'h80, 8'h80, 1'b1, 16'h4000);
        do8("s8_127xm1", 8'h7F, 8'hFF, 1'b1, 16'hFF81);

        // Back-pressure: result held while a second request waits.
        in_val = 1'b1; in_msg = {32'd20, 32'd30}; in_sgn = 1'b0;
        @(posedge clk); #1;
        out_rdy = 1'b0;
        in_val = 1'b0;
        w = 0;
        while (!out_val && w < 100) begin @(posedge clk); #1; w++; end
        in_val = 1'b1; in_msg = {32'd5, 32'd6}; in_sgn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("bp_val", out_val, 1'b1);
            check("bp_msg", out_msg, 64'd600);
            check("bp_rdy", in_rdy, 1'b0);
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {out_val, in_rdy}, 2'b01);
        @(posedge clk); #1;
        in_val = 1'b0;
        check("bp_next_accepted", in_rdy, 1'b0);
        w = 0;
        while (!out_val && w < 100) begin @(posedge clk); #1; w++; end
        check("bp_next_msg", out_msg, 64'd30);
        @(posedge clk); #1;

        // Reset pulse during the 10th CALC cycle discards the transaction.
        in_val = 1'b1; in_msg = {32'd9999, 32'd9999}; in_sgn = 1'b0;
        @(posedge clk); #1;
        in_val = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_calc_busy", in_rdy, 1'b0);
        reset = 1'b0;
        #1;
        check("mid_reset_comb", {in_rdy, out_val}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_reset_idle", in_rdy, 1'b1);
        check("mid_reset_msg", out_msg, 64'd0);
        saw_val = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_val) saw_val++;
            @(posedge clk); #1;
        end
        check("mid_reset_no_resp", saw_val, 0);
        do32("s_m3xm4", 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b1, 64'd12, 0);

        // Random pairs against a behavioural multiply with random sink stalls.
        for (int k = 0; k < 20; k++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (k % 4 == 0) rb = rb >> $urandom_range(0, 31);
            if (rs) begin
                sa = $signed(ra); sb = $signed(rb);
                rexp = sa * sb;
            end else begin
                rexp = {32'd0, ra} * {32'd0, rb};
            end
            do32("rand", ra, rb, rs, rexp, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
